// File: rtl/delay_line_latency_meter_pkg.sv
// Shared types and constants for the delay-line latency meter and its tap selection.
package delay_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEF_FLUSH_CYCLES = 128;
  localparam int unsigned DEF_TIMEOUT      = 200;

  // Selectable delay line depths; the deepest one bounds the flush length.
  localparam int unsigned STAGES_30  = 30;
  localparam int unsigned STAGES_45  = 45;
  localparam int unsigned STAGES_60  = 60;
  localparam int unsigned STAGES_90  = 90;
  localparam int unsigned STAGES_MAX = STAGES_90;

endpackage

// File: rtl/delay_line_latency_meter_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module dl_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/delay_line_latency_meter.sv
// Flushes a byte-wide delay path, injects a marker and counts cycles until it returns.
module delay_line_latency_meter
  import delay_line_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       marker,
  input  logic [7:0]       rx_data,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] latency
);

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

  state_t           state, state_nx;
  logic [7:0]       marker_q, marker_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, cnt_en;
  logic [7:0]       tx_d;
  logic             busy_d, done_d, to_d;
  logic [CNT_W-1:0] lat_d;
  logic             match;

  // One counter serves both phases: it times the flush, then restarts at 0 for C0.
  dl_sat_counter #(.W(CNT_W)) u_cnt (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .count  (cnt)
  );

  assign match = (rx_data == marker_q);

  always_comb begin
    state_nx = state;
    marker_d = marker_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    lat_d    = latency;
    to_d     = timed_out;
    case (state)
      ST_IDLE: begin
        if (start && (marker != '0)) begin
          marker_d = marker;
          cnt_clr  = 1'b1;
          lat_d    = '0;
          to_d     = 1'b0;
          state_nx = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          cnt_clr  = 1'b1;
          state_nx = ST_SEND;
        end else begin
          cnt_en = 1'b1;
        end
      end
      // SEND is C0 (count 0); a match is checked before the timeout so a hit at TIMEOUT wins.
      ST_SEND, ST_WAIT: begin
        if (match) begin
          lat_d    = cnt;
          to_d     = 1'b0;
          state_nx = ST_DONE;
        end else if (cnt >= TIMEOUT_C) begin
          lat_d    = '0;
          to_d     = 1'b1;
          state_nx = ST_DONE;
        end else begin
          cnt_en   = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase

    tx_d   = (state_nx == ST_SEND) ? marker_q : '0;
    busy_d = (state_nx == ST_FLUSH) || (state_nx == ST_SEND) || (state_nx == ST_WAIT);
    done_d = (state_nx == ST_DONE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      marker_q  <= '0;
      tx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      latency   <= '0;
    end else begin
      state     <= state_nx;
      marker_q  <= marker_d;
      tx_data   <= tx_d;
      busy      <= busy_d;
      done      <= done_d;
      timed_out <= to_d;
      latency   <= lat_d;
    end
  end

endmodule

// File: tb/tb_delay_line_latency_meter.sv
// Scoreboard bench: external delay line with selectable tap, loopback or stuck-zero return path.
module tb_delay_line_latency_meter;
  import delay_line_pkg::*;

  localparam int FLUSH = DEF_FLUSH_CYCLES;
  localparam int TMO   = DEF_TIMEOUT;
  localparam int DEPTH = TMO + 1;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] marker = 8'h00;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       busy, done, timed_out;
  logic [7:0] latency;

  int   mode = 0;  // 0 loopback, 1 delay line tap, 2 stuck at zero
  int   tap = 1;
  logic fill_en = 1'b0;
  logic [7:0] line [DEPTH];

  typedef struct {
    logic [7:0] lat;
    logic       to;
    int         busy_cycles;
  } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    line[0] <= fill_en ? 8'hA5 : tx_data;
    for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
  end

  always_comb begin
    case (mode)
      0:       rx_data = tx_data;
      1:       rx_data = line[tap-1];
      default: rx_data = 8'h00;
    endcase
  end

  delay_line_latency_meter #(
    .CNT_W        (DEF_CNT_W),
    .FLUSH_CYCLES (DEF_FLUSH_CYCLES),
    .TIMEOUT      (DEF_TIMEOUT)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .marker    (marker),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .timed_out (timed_out),
    .latency   (latency)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (DEPTH + 10) @(negedge clock);
    total++; if (tx_data !== 8'h00) $display("FAIL reset_tx got %h want 00", tx_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (timed_out !== 1'b0) $display("FAIL reset_timed_out got %b want 0", timed_out); else passed++;
    total++; if (latency !== 8'h00) $display("FAIL reset_latency got %h want 00", latency); else passed++;
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  // Runs one measurement; poke >= 0 raises start with another marker at that busy-cycle index.
  task automatic measure(input string name, input int m, input int tp, input logic [7:0] mk,
                         input int poke);
    exp_t e, got;
    int   busy_n, send_n, send_idx;
    logic [7:0] send_val;
    bit   seen;
    mode = m;
    tap  = tp;
    e.to  = (m == 2) || (m == 1 && tp > TMO);
    e.lat = (e.to || m == 0) ? 8'h00 : 8'(tp);
    e.busy_cycles = FLUSH + 1 + (e.to ? TMO : int'(e.lat));
    sb.push_back(e);

    @(negedge clock);
    marker = mk;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    marker = 8'h00;
    busy_n = 0; send_n = 0; send_idx = -1; send_val = 8'h00; seen = 0;
    for (int idx = 0; idx < 1000 && !seen; idx++) begin
      if (idx > 0) @(negedge clock);
      if (poke == idx) begin
        start = 1'b1; marker = 8'hC3;
      end else if (poke == idx - 1) begin
        start = 1'b0; marker = 8'h00;
      end
      if (busy === 1'b1) busy_n++;
      if (tx_data !== 8'h00) begin
        send_n++; send_idx = idx; send_val = tx_data;
      end
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    got = sb.pop_front();
    total++;
    if (!seen) begin
      $display("FAIL %s_done_wait no done within 1000 cycles", name);
      return;
    end else passed++;
    total++; if (latency !== got.lat) $display("FAIL %s_latency got %0d want %0d", name, latency, got.lat); else passed++;
    total++; if (timed_out !== got.to) $display("FAIL %s_timed_out got %b want %b", name, timed_out, got.to); else passed++;
    total++; if (busy_n !== got.busy_cycles) $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_n, got.busy_cycles); else passed++;
    total++; if (send_n !== 1) $display("FAIL %s_send_count got %0d want 1", name, send_n); else passed++;
    total++; if (send_idx !== FLUSH) $display("FAIL %s_send_cycle got %0d want %0d", name, send_idx, FLUSH); else passed++;
    total++; if (send_val !== mk) $display("FAIL %s_send_value got %h want %h", name, send_val, mk); else passed++;
    @(negedge clock);
    total++; if (done !== 1'b0) $display("FAIL %s_done_pulse got %b want 0", name, done); else passed++;
    total++; if (latency !== got.lat || timed_out !== got.to)
      $display("FAIL %s_hold got %0d/%b want %0d/%b", name, latency, timed_out, got.lat, got.to);
    else passed++;
  endtask

  task automatic test_marker_zero();
    int busy_seen, done_seen;
    busy_seen = 0; done_seen = 0;
    @(negedge clock);
    marker = 8'h00;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) busy_seen++;
      if (done === 1'b1) done_seen++;
      @(negedge clock);
    end
    total++; if (busy_seen !== 0) $display("FAIL marker0_busy got %0d busy cycles want 0", busy_seen); else passed++;
    total++; if (done_seen !== 0) $display("FAIL marker0_done got %0d done cycles want 0", done_seen); else passed++;
    total++; if (timed_out !== 1'b1 || latency !== 8'h00)
      $display("FAIL marker0_status got %0d/%b want 0/1", latency, timed_out);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    bad = 0;
    mode = 1;
    tap  = STAGES_60;
    @(negedge clock);
    marker = 8'h5A;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    marker = 8'h00;
    repeat (FLUSH + 20) @(negedge clock);
    rst_n = 1'b0;
    #1;
    total++; if (tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0 || latency !== 8'h00)
      $display("FAIL midreset_outputs got tx=%h busy=%b done=%b to=%b lat=%0d want all 0",
               tx_data, busy, done, timed_out, latency);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL midreset_quiet got %0d active cycles want 0", bad); else passed++;
    rst_n = 1'b1;
    @(negedge clock);
    measure("after_reset", 1, STAGES_60, 8'h5A, -1);
  endtask

  task automatic test_prefill();
    mode = 1;
    tap  = STAGES_45;
    fill_en = 1'b1;
    repeat (DEPTH + 10) @(negedge clock);
    fill_en = 1'b0;
    measure("prefill", 1, STAGES_45, 8'hA5, -1);
  endtask

  initial begin
    test_reset();
    measure("loopback", 0, 1, 8'hA5, -1);
    measure("tap30", 1, STAGES_30, 8'h5A, -1);
    measure("tap90", 1, STAGES_90, 8'h5A, -1);
    measure("timeout", 2, 1, 8'h5A, -1);
    test_marker_zero();
    measure("start_in_wait", 1, STAGES_30, 8'h81, FLUSH + 12);
    test_reset_mid_wait();
    test_prefill();
    measure("match_at_timeout", 1, TMO, 8'h5A, -1);
    measure("past_timeout", 1, TMO + 1, 8'h5A, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
